// File: rtl/serial_test_pkg.sv
// serial_test_pkg: shared widths, FSM states and transaction length for the serial test link master
package serial_test_pkg;

    localparam int IN_BITS_DEF   = 48;
    localparam int OUT_BITS_DEF  = 53;
    localparam int IN_ADDR_BITS  = 6;
    localparam int OUT_ADDR_BITS = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_RST,
        S_SHIFT_IN,
        S_SETTLE,
        S_CAP_RST,
        S_SHIFT_OUT
    } state_t;

    // Number of busy cycles of one transaction, from the cycle after start to the cycle before done
    function automatic int xfer_cycles(input int in_bits, input int out_bits, input int half_period, input int settle_cycles);
        return 2 * half_period * (in_bits + 1) + settle_cycles + 2 * half_period * (out_bits + 1);
    endfunction

endpackage

// File: rtl/serial_slot_timer.sv
// serial_slot_timer: position within one serial-clock slot of 2*HALF_PERIOD system clocks
module serial_slot_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic slot_start,
    output logic sample_strobe,
    output logic clk_level,
    output logic slot_end
);

    localparam int CW = $clog2(2 * HALF_PERIOD);
    localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] HIGH_AT   = CW'(HALF_PERIOD);
    localparam logic [CW-1:0] LAST_AT   = CW'(2 * HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    // Slot position; parked at 0 while the FSM is not clocking the link so each phase starts on a slot boundary
    always_ff @(posedge clk) begin
        cnt <= (rst || !run || slot_end) ? '0 : cnt + 1'b1;
    end

    assign slot_start    = cnt == '0;
    assign sample_strobe = cnt == SAMPLE_AT;
    assign clk_level     = cnt >= HIGH_AT;
    assign slot_end      = cnt == LAST_AT;

endmodule

// File: rtl/serial_test_driver.sv
// serial_test_driver: link master that loads a vector into serial_tester, waits, and reads the result back
module serial_test_driver
    import serial_test_pkg::*;
#(
    parameter int IN_BITS       = IN_BITS_DEF,
    parameter int OUT_BITS      = OUT_BITS_DEF,
    parameter int HALF_PERIOD   = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_BITS-1:0]  vec,
    output logic                busy,
    output logic                done,
    output logic [OUT_BITS-1:0] result,
    output logic                ser_in_clk,
    output logic                ser_in_data,
    output logic                ser_in_rst,
    output logic                ser_out_clk,
    output logic                ser_out_rst,
    input  logic                ser_out_data
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IN_ADDR_BITS-1:0]  IN_LAST     = IN_ADDR_BITS'(IN_BITS - 1);
    localparam logic [OUT_ADDR_BITS-1:0] OUT_LAST    = OUT_ADDR_BITS'(OUT_BITS - 1);
    localparam logic [SW-1:0]            SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [IN_ADDR_BITS-1:0] bit_cnt, bit_nxt;
    logic [SW-1:0]           settle_cnt;
    logic [IN_BITS-1:0]      vec_q;
    logic [OUT_BITS-1:0]     shift;
    logic [1:0]              sync;
    logic                    slot_start, sample_strobe, clk_level, slot_end;
    logic                    run, lvl_nxt, last_out;

    serial_slot_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .slot_start   (slot_start),
        .sample_strobe(sample_strobe),
        .clk_level    (clk_level),
        .slot_end     (slot_end)
    );

    assign run      = !(state == S_IDLE || state == S_SETTLE);
    assign busy     = state != S_IDLE;
    assign lvl_nxt  = sample_strobe || (clk_level && !slot_end);
    assign last_out = state == S_SHIFT_OUT && slot_end && bit_cnt == OUT_LAST;

    // Phase sequencing; the bit counter is shared by both shift phases and returns to 0 between them
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        case (state)
            S_IDLE:      state_nxt = start ? S_LOAD_RST : S_IDLE;
            S_LOAD_RST:  state_nxt = slot_end ? S_SHIFT_IN : S_LOAD_RST;
            S_SHIFT_IN: begin
                state_nxt = (slot_end && bit_cnt == IN_LAST) ? S_SETTLE : S_SHIFT_IN;
                bit_nxt   = !slot_end ? bit_cnt : (bit_cnt == IN_LAST) ? '0 : bit_cnt + 1'b1;
            end
            S_SETTLE:    state_nxt = (settle_cnt == SETTLE_LAST) ? S_CAP_RST : S_SETTLE;
            S_CAP_RST:   state_nxt = slot_end ? S_SHIFT_OUT : S_CAP_RST;
            S_SHIFT_OUT: begin
                state_nxt = last_out ? S_IDLE : S_SHIFT_OUT;
                bit_nxt   = !slot_end ? bit_cnt : last_out ? '0 : bit_cnt + 1'b1;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and serial lines; the lines are registered from next-cycle values so they never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            settle_cnt  <= '0;
            vec_q       <= '0;
            shift       <= '0;
            sync        <= '0;
            result      <= '0;
            done        <= 1'b0;
            ser_in_clk  <= 1'b0;
            ser_in_data <= 1'b0;
            ser_in_rst  <= 1'b0;
            ser_out_clk <= 1'b0;
            ser_out_rst <= 1'b0;
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_nxt;
            settle_cnt  <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            sync        <= {sync[0], ser_out_data};
            done        <= last_out;
            ser_in_clk  <= lvl_nxt && (state == S_LOAD_RST || state == S_SHIFT_IN);
            ser_out_clk <= lvl_nxt && (state == S_CAP_RST || state == S_SHIFT_OUT);
            ser_in_rst  <= state_nxt == S_LOAD_RST;
            ser_out_rst <= state_nxt == S_CAP_RST;
            ser_in_data <= state_nxt == S_SHIFT_IN && vec_q[bit_nxt];
            if (state == S_IDLE && start)
                vec_q <= vec;
            if (state == S_CAP_RST && slot_start)
                shift <= '0;
            if (state == S_SHIFT_OUT && sample_strobe)
                shift[bit_cnt] <= sync[1];
            if (last_out)
                result <= shift;
        end
    end

endmodule
